tiro_aliado: RTL and testbench

//   Allied-shot controller. Launches one projectile from the player ship when the fire button is pressed,
//   and steps it upward at a fixed rate. Detects a hit against the enemy rectangle and keeps a saturating hit score.

---
 rtl/tiro_aliado.sv | 134 +++++++++++++
 tb/tb_tiro_aliado.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tiro_aliado.sv
// Allied-shot controller: launches one projectile from the ship on a fire edge,
// steps it upward on a divided tick and keeps a saturating hit score.
module tiro_aliado #(
    parameter int H_OFF    = 144,
    parameter int V_OFF    = 35,
    parameter int RAIO     = 4,
    parameter int PASSO    = 6,
    parameter int DIV      = 833333,
    parameter int COOLDOWN = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ativo,
    input  logic       disparo,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic [9:0] largura_nave,
    input  logic [9:0] x_inimigo,
    input  logic [9:0] y_inimigo,
    input  logic [9:0] largura_inimigo,
    input  logic [9:0] altura_inimigo,
    output logic [9:0] x_bola_aliada,
    output logic [9:0] y_bola_aliada,
    output logic [9:0] raio_bola_aliada,
    output logic       acerto,
    output logic [7:0] pontos
);
    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    typedef enum logic [1:0] {PRONTO, VOANDO, RECARGA} estado_t;
    estado_t estado, estado_prox;

    logic [TW-1:0] conta_tick;
    logic [CW-1:0] conta_recarga;
    logic          tick;
    logic          disparo_q;
    logic          borda_disparo;
    logic [10:0]   x_bola, y_bola;
    logic [10:0]   x_lanc, y_lanc;
    logic [10:0]   x_min, x_max, y_min, y_max;
    logic          dentro, fora, fim_recarga;
    logic          evento_acerto;
    logic          lanca, sobe;

    assign tick          = (conta_tick == TW'(DIV - 1));
    assign borda_disparo = disparo & ~disparo_q;
    assign fim_recarga   = (conta_recarga == CW'(COOLDOWN - 1));

    // All geometry is done in 11 bits so offsets added to 10-bit inputs can carry.
    assign x_lanc = {1'b0, x_nave} + ({1'b0, largura_nave} >> 1) + 11'(H_OFF);
    assign y_lanc = {1'b0, y_nave} + 11'(V_OFF) - 11'(RAIO);
    assign x_min  = {1'b0, x_inimigo} + 11'(H_OFF);
    assign x_max  = x_min + {1'b0, largura_inimigo};
    assign y_min  = {1'b0, y_inimigo} + 11'(V_OFF);
    assign y_max  = y_min + {1'b0, altura_inimigo};
    assign dentro = (x_bola >= x_min) && (x_bola <= x_max) &&
                    (y_bola >= y_min) && (y_bola <= y_max);
    assign fora   = (y_bola < 11'(V_OFF + PASSO + RAIO));

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            estado <= PRONTO;
        else
            estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        if (!ativo) begin
            estado_prox = PRONTO;
        end else begin
            case (estado)
                PRONTO:  if (borda_disparo) estado_prox = VOANDO;
                VOANDO:  if (tick && (dentro || fora)) estado_prox = RECARGA;
                RECARGA: if (tick && fim_recarga) estado_prox = PRONTO;
                default: estado_prox = PRONTO;
            endcase
        end
    end

    always_comb begin
        raio_bola_aliada = '0;
        evento_acerto    = 1'b0;
        lanca            = 1'b0;
        sobe             = 1'b0;
        if (estado == VOANDO)
            raio_bola_aliada = 10'(RAIO);
        if (ativo) begin
            lanca         = (estado == PRONTO) && borda_disparo;
            evento_acerto = (estado == VOANDO) && tick && dentro;
            sobe          = (estado == VOANDO) && tick && !dentro && !fora;
        end
    end

    // Free-running step divider; one-cycle tick on the last count.
    always_ff @(posedge CLOCK_50) begin
        if (reset || tick)
            conta_tick <= '0;
        else
            conta_tick <= conta_tick + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            disparo_q     <= 1'b0;
            x_bola        <= '0;
            y_bola        <= '0;
            conta_recarga <= '0;
            acerto        <= 1'b0;
            pontos        <= '0;
        end else begin
            disparo_q <= disparo;
            acerto    <= evento_acerto;
            if (evento_acerto && pontos != 8'hFF)
                pontos <= pontos + 8'd1;
            if (lanca) begin
                x_bola <= x_lanc;
                y_bola <= y_lanc;
            end else if (sobe) begin
                y_bola <= y_bola - 11'(PASSO);
            end
            // Counter restarts whenever the controller is not reloading.
            if (estado != RECARGA)
                conta_recarga <= '0;
            else if (tick)
                conta_recarga <= conta_recarga + 1'b1;
        end
    end

    assign x_bola_aliada = x_bola[9:0];
    assign y_bola_aliada = y_bola[9:0];

endmodule

// File: tb/tb_tiro_aliado.sv
// Bench for tiro_aliado: directed scenarios with literal expectations plus
// random stimulus, all outputs compared every cycle against a behavioural model.
module tb_tiro_aliado;
    localparam int H_OFF = 144, V_OFF = 35, RAIO = 4, PASSO = 6, DIV = 4, COOLDOWN = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1, ativo = 1'b1, disparo = 1'b0;
    logic [9:0] x_nave = 0, y_nave = 0, largura_nave = 0;
    logic [9:0] x_inimigo = 0, y_inimigo = 0, largura_inimigo = 0, altura_inimigo = 0;
    logic [9:0] x_bola_aliada, y_bola_aliada, raio_bola_aliada;
    logic       acerto;
    logic [7:0] pontos;

    int checks = 0, errors = 0;

    tiro_aliado #(.H_OFF(H_OFF), .V_OFF(V_OFF), .RAIO(RAIO), .PASSO(PASSO),
                  .DIV(DIV), .COOLDOWN(COOLDOWN)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .ativo(ativo), .disparo(disparo),
        .x_nave(x_nave), .y_nave(y_nave), .largura_nave(largura_nave),
        .x_inimigo(x_inimigo), .y_inimigo(y_inimigo),
        .largura_inimigo(largura_inimigo), .altura_inimigo(altura_inimigo),
        .x_bola_aliada(x_bola_aliada), .y_bola_aliada(y_bola_aliada),
        .raio_bola_aliada(raio_bola_aliada), .acerto(acerto), .pontos(pontos)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: flying flag, remaining reload ticks, ball position, score.
    int  cyc_in_period = 0, tick_count = 0;
    bit  m_flying = 0, m_acerto = 0, m_dq = 0, started = 0;
    int  m_cool_left = 0, m_x = 0, m_y = 0, m_pontos = 0;
    bit  m_tick, m_edge;

    function automatic bit hits_enemy(int bx, int by);
        int xl, xh, yl, yh;
        xl = (x_inimigo + H_OFF) & 2047;
        xh = (xl + largura_inimigo) & 2047;
        yl = (y_inimigo + V_OFF) & 2047;
        yh = (yl + altura_inimigo) & 2047;
        return bx >= xl && bx <= xh && by >= yl && by <= yh;
    endfunction

    always @(posedge CLOCK_50) begin
        started = 1;
        if (reset) begin
            cyc_in_period = 0; m_flying = 0; m_cool_left = 0;
            m_x = 0; m_y = 0; m_pontos = 0; m_acerto = 0; m_dq = 0;
        end else begin
            m_tick = (cyc_in_period == DIV - 1);
            cyc_in_period = (cyc_in_period + 1) % DIV;
            if (m_tick) tick_count++;
            m_edge = disparo && !m_dq;
            m_acerto = 0;
            if (!ativo) begin
                m_flying = 0;
                m_cool_left = 0;
            end else if (m_flying) begin
                if (m_tick) begin
                    if (hits_enemy(m_x, m_y)) begin
                        m_acerto = 1;
                        if (m_pontos < 255) m_pontos++;
                        m_flying = 0;
                        m_cool_left = COOLDOWN;
                    end else if (m_y < V_OFF + PASSO + RAIO) begin
                        m_flying = 0;
                        m_cool_left = COOLDOWN;
                    end else begin
                        m_y = (m_y - PASSO) & 2047;
                    end
                end
            end else if (m_cool_left > 0) begin
                if (m_tick) m_cool_left--;
            end else if (m_edge) begin
                m_flying = 1;
                m_x = (x_nave + largura_nave / 2 + H_OFF) & 2047;
                m_y = (y_nave + V_OFF - RAIO) & 2047;
            end
            m_dq = disparo;
        end
    end

    always @(negedge CLOCK_50) begin
        if (started) begin
            checkOutput("raio", raio_bola_aliada, m_flying ? RAIO : 0);
            checkOutput("x", x_bola_aliada, m_x & 1023);
            checkOutput("y", y_bola_aliada, m_y & 1023);
            checkOutput("acerto", acerto, m_acerto);
            checkOutput("pontos", pontos, m_pontos);
        end
    end

    task automatic step();
        @(posedge CLOCK_50); #1;
    endtask

    task automatic waitTicks(input int n);
        int target, budget;
        target = tick_count + n;
        budget = n * DIV + DIV + 4;
        while (tick_count < target && budget > 0) begin
            step();
            budget--;
        end
        if (tick_count < target) checkOutput("tick_timeout", tick_count, target);
    endtask

    task automatic fire();
        disparo = 1'b0; step();
        disparo = 1'b1; step();
    endtask

    task automatic applyStimulus();
        step();
        reset = ($urandom_range(0, 299) == 0);
        ativo = ($urandom_range(0, 149) != 0);
        if ($urandom_range(0, 3) == 0) disparo = ~disparo;
        if ($urandom_range(0, 99) == 0) begin
            x_nave = 10'($urandom_range(90, 110));
            y_nave = 10'($urandom_range(40, 200));
            largura_nave = 10'($urandom_range(0, 30));
            x_inimigo = 10'($urandom_range(80, 140));
            y_inimigo = 10'($urandom_range(0, 200));
            largura_inimigo = 10'($urandom_range(5, 40));
            altura_inimigo = 10'($urandom_range(5, 40));
        end
    endtask

    initial begin
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("reset_raio", raio_bola_aliada, 0);
        checkOutput("reset_x", x_bola_aliada, 0);
        checkOutput("reset_y", y_bola_aliada, 0);
        checkOutput("reset_pontos", pontos, 0);
        checkOutput("reset_acerto", acerto, 0);
        reset = 1'b0;

        // Miss: enemy well off the ball's column; disparo held through the flight.
        x_nave = 100; y_nave = 400; largura_nave = 14;
        x_inimigo = 600; y_inimigo = 10; largura_inimigo = 5; altura_inimigo = 5;
        step();
        disparo = 1'b1; step();
        checkOutput("fire_x", x_bola_aliada, 251);
        checkOutput("fire_y", y_bola_aliada, 431);
        checkOutput("fire_raio", raio_bola_aliada, 4);
        waitTicks(1);
        checkOutput("y_tick1", y_bola_aliada, 425);
        waitTicks(9);
        checkOutput("y_tick10", y_bola_aliada, 371);
        waitTicks(55);
        checkOutput("y_tick65", y_bola_aliada, 41);
        checkOutput("raio_tick65", raio_bola_aliada, 4);
        waitTicks(1);
        checkOutput("miss_raio", raio_bola_aliada, 0);
        checkOutput("miss_acerto", acerto, 0);
        waitTicks(2);

        // Hit on the sixteenth tick.
        x_inimigo = 95; y_inimigo = 300; largura_inimigo = 20; altura_inimigo = 10;
        fire();
        checkOutput("fire2_raio", raio_bola_aliada, 4);
        waitTicks(15);
        checkOutput("y_tick15", y_bola_aliada, 341);
        waitTicks(1);
        checkOutput("hit_acerto", acerto, 1);
        checkOutput("hit_pontos", pontos, 1);
        checkOutput("hit_raio", raio_bola_aliada, 0);
        checkOutput("hit_y", y_bola_aliada, 341);
        fire();
        checkOutput("acerto_pulse", acerto, 0);
        checkOutput("reload_ignores_fire", raio_bola_aliada, 0);
        waitTicks(2);
        fire();
        checkOutput("refire_raio", raio_bola_aliada, 4);

        // Abort mid-flight.
        ativo = 1'b0; step();
        checkOutput("abort_raio", raio_bola_aliada, 0);
        checkOutput("abort_pontos", pontos, 1);
        ativo = 1'b1;

        // Enemy straddling the launch point: every shot hits on its first tick.
        x_inimigo = 100; y_inimigo = 390; largura_inimigo = 30; altura_inimigo = 20;
        for (int i = 0; i < 256; i++) begin
            fire();
            waitTicks(4);
        end
        checkOutput("pontos_saturated", pontos, 255);

        for (int i = 0; i < 2500; i++) applyStimulus();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
